rename_free_list: RTL

- Physical-register free list for the Tomasulo rename stage.
- Hands free physical tags to RegisterRenaming at dispatch.
- Reclaims the previous mapping's tag when an instruction with a destination commits.
- Rolls speculative allocations back to the committed point on flush.
- Circular buffer of tags with three pointers: head (speculative allocate), arch_head (committed allocate) and tail (free insert).

---
 rtl/rename_free_list.sv | 106 ++++++++++
 1 files changed

// File: rtl/rename_free_list.sv
// rename_free_list
// ----------------
// Physical-register free list for the Tomasulo rename stage. Free tags live
// in a circular buffer. Three pointers walk it:
//   head      - next tag to hand out (speculative allocate point)
//   arch_head - allocate point as seen by committed instructions
//   tail      - next slot to receive a reclaimed tag
// On a flush, head is pulled back to arch_head. This returns every
// speculatively allocated tag to the list in one cycle.
//
// Ports:
//   clk             in   clock, all state updates on the rising edge
//   reset           in   synchronous active-high reset
//   alloc_req       in   dispatch wants one free tag this cycle
//   alloc_gnt       out  request accepted; alloc_preg is consumed at the edge
//   alloc_preg      out  tag at the head entry
//   commit          in   an instruction with a destination retires
//   commit_old_preg in   previous mapping of that destination, to be freed
//   flush           in   mispredict/exception recovery
//   free_count      out  number of free tags (tail - head)
//   empty           out  no free tags
//   overflow        out  sticky error: a tag was freed into a full list

module rename_free_list #(
    parameter int NUM_PHYS = 32,
    parameter int NUM_ARCH = 8,
    localparam int PREG_W  = $clog2(NUM_PHYS),
    localparam int PTR_W   = $clog2(NUM_PHYS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              commit,
    input  logic [PREG_W-1:0] commit_old_preg,
    input  logic              flush,
    output logic [PTR_W-1:0]  free_count,
    output logic              empty,
    output logic              overflow
);

    logic [PREG_W-1:0] entries [NUM_PHYS];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  arch_head;
    logic [PTR_W-1:0]  tail;

    logic              full;
    logic              commit_ok;
    logic              commit_drop;
    logic [PTR_W-1:0]  arch_head_next;
    logic [PTR_W-1:0]  tail_next;

    // Pointers carry an extra wrap bit. tail - head is then the true
    // occupancy, and 0 (empty) and NUM_PHYS (full) can be told apart.
    always_comb begin
        free_count = tail - head;
        empty      = (free_count == '0);
        full       = (free_count == PTR_W'(NUM_PHYS));
        alloc_preg = entries[head[PTR_W-2:0]];
        alloc_gnt  = alloc_req & ~empty & ~flush & ~reset;
    end

    // A commit into a full list has nowhere to go, unless the same cycle
    // also frees a slot with an allocate. In that case the write is dropped
    // and the error is latched. arch_head still follows the commit stream,
    // so a flush always lands on the committed point.
    always_comb begin
        commit_drop    = commit & full & ~alloc_gnt;
        commit_ok      = commit & ~commit_drop;
        arch_head_next = arch_head + {{(PTR_W-1){1'b0}}, commit};
        tail_next      = tail + {{(PTR_W-1){1'b0}}, commit_ok};
    end

    // Reset preloads slot i with tag NUM_ARCH+i, and the tag value wraps
    // modulo NUM_PHYS. The slots that do not hold free tags therefore get
    // the architectural tags. They sit outside head..tail and are never
    // read before being rewritten. A flush takes priority over an allocate;
    // alloc_gnt is already low during a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                entries[i] <= PREG_W'(NUM_ARCH + i);
            end
            head      <= '0;
            arch_head <= '0;
            tail      <= PTR_W'(NUM_PHYS - NUM_ARCH);
            overflow  <= 1'b0;
        end else begin
            if (commit_ok) begin
                entries[tail[PTR_W-2:0]] <= commit_old_preg;
            end
            tail      <= tail_next;
            arch_head <= arch_head_next;
            if (flush) begin
                head <= arch_head_next;
            end else if (alloc_gnt) begin
                head <= head + 1'b1;
            end
            if (commit_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
